// File: rtl/sw_select.sv
// sw_select: 2-flop sync and debounce of a mode button and 4 switches; each button press steps a one-hot destination select.
// Latency: debounced values DEB_CYCLES+2 cycles after a raw change settles; adress DEB_CYCLES+3 cycles after a press begins.
// Backpressure: none, free-running with outputs valid every cycle. Define SW_SELECT_TIMEOUT_EN to add the idle return-to-default.
module sw_select #(
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic [3:0] sw_raw,
  output logic [3:0] adress,
  output logic [3:0] sw_out,
  output logic       sel_pulse
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_DEF = 3'd0,
    ST_S1  = 3'd1,
    ST_S2  = 3'd2,
    ST_S3  = 3'd3,
    ST_S4  = 3'd4
  } state_t;

  // s1/s2 form the synchronizer; s3 is the synced value one cycle earlier
  logic       btn_s1_q, btn_s2_q, btn_s3_q;
  logic [3:0] sw_s1_q, sw_s2_q, sw_s3_q;
  logic [7:0] btn_cnt_q, btn_cnt_d;
  logic [7:0] sw_cnt_q, sw_cnt_d;
  logic       btn_deb_q, btn_deb_d, btn_deb_prev_q;
  logic [3:0] sw_deb_q, sw_deb_d;
  logic       press;
  logic       timeout;
  state_t     state_q, state_d;
  logic [3:0] adress_q, adress_d;
  logic       sel_pulse_q;

  // Synchronizer chains for the raw asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
      sw_s1_q  <= 4'b0000;
      sw_s2_q  <= 4'b0000;
      sw_s3_q  <= 4'b0000;
    end else begin
      btn_s1_q <= btn_mode;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
      sw_s3_q  <= sw_s2_q;
    end
  end

  // Button debounce: count only while the synced value is new and unchanged
  always_comb begin
    btn_cnt_d = '0;
    btn_deb_d = btn_deb_q;
    if ((btn_s2_q != btn_deb_q) && (btn_s2_q == btn_s3_q)) begin
      if (btn_cnt_q == DEB_LAST) btn_deb_d = btn_s2_q;
      else                       btn_cnt_d = btn_cnt_q + 8'd1;
    end
  end

  // Switch debounce: whole vector at once, any bit change restarts the count
  always_comb begin
    sw_cnt_d = '0;
    sw_deb_d = sw_deb_q;
    if ((sw_s2_q != sw_deb_q) && (sw_s2_q == sw_s3_q)) begin
      if (sw_cnt_q == DEB_LAST) sw_deb_d = sw_s2_q;
      else                      sw_cnt_d = sw_cnt_q + 8'd1;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_cnt_q      <= '0;
      sw_cnt_q       <= '0;
      btn_deb_q      <= 1'b0;
      btn_deb_prev_q <= 1'b0;
      sw_deb_q       <= 4'b0000;
    end else begin
      btn_cnt_q      <= btn_cnt_d;
      sw_cnt_q       <= sw_cnt_d;
      btn_deb_q      <= btn_deb_d;
      btn_deb_prev_q <= btn_deb_q;
      sw_deb_q       <= sw_deb_d;
    end
  end

  // A press is the 0->1 edge of the debounced button; release does nothing
  assign press = btn_deb_q & ~btn_deb_prev_q;

`ifdef SW_SELECT_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_q, idle_d;

  assign timeout = (state_q != ST_DEF) && (idle_q == TMO_LAST);

  // Idle counter: parked at 0 in DEF, cleared by a press or timeout, else counts
  always_comb begin
    idle_d = '0;
    if ((state_q != ST_DEF) && !press && !timeout) idle_d = idle_q + 16'd1;
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic [15:0] unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
`endif

  // Next state: a press advances (and beats a simultaneous timeout); unknown codes fall back to DEF
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DEF:  if (press) state_d = ST_S1;
      ST_S1:   state_d = press ? ST_S2  : (timeout ? ST_DEF : ST_S1);
      ST_S2:   state_d = press ? ST_S3  : (timeout ? ST_DEF : ST_S2);
      ST_S3:   state_d = press ? ST_S4  : (timeout ? ST_DEF : ST_S3);
      ST_S4:   state_d = (press || timeout) ? ST_DEF : ST_S4;
      default: state_d = ST_DEF;
    endcase
  end

  // Output code decoded from the next state so adress moves on the same edge as the state
  always_comb begin
    adress_d = 4'b0000;
    case (state_d)
      ST_S1:   adress_d = 4'b0001;
      ST_S2:   adress_d = 4'b0010;
      ST_S3:   adress_d = 4'b0100;
      ST_S4:   adress_d = 4'b1000;
      default: adress_d = 4'b0000;
    endcase
  end

  // State, registered select and its change strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DEF;
      adress_q    <= 4'b0000;
      sel_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      adress_q    <= adress_d;
      sel_pulse_q <= (adress_d != adress_q);
    end
  end

  assign adress    = adress_q;
  assign sw_out    = sw_deb_q;
  assign sel_pulse = sel_pulse_q;

endmodule

// File: tb/tb_sw_select.sv
module tb_sw_select;
  localparam int DEB = 4;
  localparam int TMO = 20;
`ifdef SW_SELECT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic [3:0] adress;
  logic [3:0] sw_out;
  logic       sel_pulse;

  always #5 clk = ~clk;

  sw_select #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .sw_raw(sw_raw),
    .adress(adress), .sw_out(sw_out), .sel_pulse(sel_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = -1;

  // Reference model: raw sample history per edge, debounced values, select state 0..4
  logic       b_hist[$];
  logic [3:0] s_hist[$];
  logic       m_bdeb, m_bdeb_p, m_sel;
  logic [3:0] m_sdeb;
  int         m_state, m_last_press;

  function automatic logic [3:0] model_adr();
    if (m_state == 0) return 4'b0000;
    return 4'(1 << (m_state - 1));
  endfunction

  task automatic model_edge();
    int  n, old;
    bit  bst, sst, prs;
    if (rst) begin
      b_hist = {};
      s_hist = {};
      for (int i = 0; i < DEB + 3; i++) begin
        b_hist.push_back(1'b0);
        s_hist.push_back(4'b0000);
      end
      m_bdeb = 1'b0; m_bdeb_p = 1'b0; m_sdeb = 4'b0000;
      m_state = 0; m_last_press = cyc; m_sel = 1'b0;
      return;
    end
    b_hist.push_back(btn_mode);
    s_hist.push_back(sw_raw);
    if (b_hist.size() > 3 * DEB + 8) begin
      void'(b_hist.pop_front());
      void'(s_hist.pop_front());
    end
    n   = b_hist.size();
    prs = m_bdeb && !m_bdeb_p;
    // A value is accepted once the synced input (raw two edges late) has held it for DEB+1 samples
    bst = 1'b1; sst = 1'b1;
    for (int i = n - 3 - DEB; i <= n - 3; i++) begin
      if (b_hist[i] != b_hist[n-3]) bst = 1'b0;
      if (s_hist[i] != s_hist[n-3]) sst = 1'b0;
    end
    m_bdeb_p = m_bdeb;
    if (bst && b_hist[n-3] != m_bdeb) m_bdeb = b_hist[n-3];
    if (sst && s_hist[n-3] != m_sdeb) m_sdeb = s_hist[n-3];
    old = m_state;
    if (prs) begin
      m_state = (m_state + 1) % 5;
      m_last_press = cyc;
    end else if (TO_EN && m_state != 0 && (cyc - m_last_press) == TMO) begin
      m_state = 0;
    end
    m_sel = (m_state != old);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("model_adress", adress, model_adr());
    check("model_sw_out", sw_out, m_sdeb);
    check("model_sel_pulse", {3'b000, sel_pulse}, {3'b000, m_sel});
  endtask

  task automatic press(output int t0, output int pulses);
    pulses = 0;
    t0 = cyc + 1;
    btn_mode = 1'b1;
    repeat (8) begin step(); if (sel_pulse) pulses++; end
    btn_mode = 1'b0;
    repeat (8) begin step(); if (sel_pulse) pulses++; end
  endtask

  initial begin
    int t0, pulses, len;
    logic [3:0] exp_seq[4];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0000;

    // Reset state
    rst = 1'b1;
    step();
    check("reset_adress", adress, 4'b0000);
    check("reset_sw_out", sw_out, 4'b0000);
    check("reset_sel", {3'b000, sel_pulse}, 4'b0000);

    // Button already high on the first cycle out of reset: one press, adress at edge 7
    rst = 1'b0;
    btn_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("first_press_adress", adress, (i >= 7) ? 4'b0001 : 4'b0000);
      check("first_press_sel", {3'b000, sel_pulse}, (i == 7) ? 4'b0001 : 4'b0000);
    end
    btn_mode = 1'b0;
    repeat (8) step();

    // Remaining four presses walk the ring back to default
    for (int p = 0; p < 4; p++) begin
      press(t0, pulses);
      check("ring_adress", adress, exp_seq[p]);
      check("ring_pulses", 4'(pulses), 4'd1);
    end

    // Short glitches on the button and bouncing switches are ignored
    btn_mode = 1'b1; sw_raw = 4'b1010; step();
    sw_raw = 4'b0000; step();
    sw_raw = 4'b1010; step();
    btn_mode = 1'b0; sw_raw = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      check("glitch_adress", adress, 4'b0000);
      check("glitch_sw_out", sw_out, 4'b0000);
    end
    sw_raw = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      step();
      check("sw_latency", sw_out, (i >= 6) ? 4'b1010 : 4'b0000);
    end

`ifdef SW_SELECT_TIMEOUT_EN
    // Idle in S2: back to default twenty cycles after the select changed
    press(t0, pulses);
    press(t0, pulses);
    while (cyc < t0 + 26) step();
    check("timeout_before", adress, 4'b0010);
    step();
    check("timeout_adress", adress, 4'b0000);
    check("timeout_sel", {3'b000, sel_pulse}, 4'b0001);

    // Press landing in the timeout cycle wins
    press(t0, pulses);
    t0 = cyc + 1;
    btn_mode = 1'b1;
    repeat (8) step();
    btn_mode = 1'b0;
    while (cyc < t0 + 19) step();
    btn_mode = 1'b1;
    while (cyc < t0 + 26) step();
    check("press_wins_before", adress, 4'b0010);
    step();
    check("press_wins_adress", adress, 4'b0100);
    check("press_wins_sel", {3'b000, sel_pulse}, 4'b0001);
    btn_mode = 1'b0;
    repeat (10) step();
`else
    // Without the timeout the select holds indefinitely
    press(t0, pulses);
    for (int i = 0; i < 100; i++) begin
      step();
      check("no_timeout_adress", adress, 4'b0001);
      check("no_timeout_sel", {3'b000, sel_pulse}, 4'b0000);
    end
    press(t0, pulses);
    press(t0, pulses);
`endif

    // Reset in S3 with a press half-debounced: nothing pending survives
    check("pre_reset_adress", adress, 4'b0100);
    btn_mode = 1'b1; sw_raw = 4'b0101;
    repeat (3) step();
    rst = 1'b1; btn_mode = 1'b0;
    step();
    check("midrst_adress", adress, 4'b0000);
    check("midrst_sw_out", sw_out, 4'b0000);
    check("midrst_sel", {3'b000, sel_pulse}, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst_adress", adress, 4'b0000);
      check("post_rst_sel", {3'b000, sel_pulse}, 4'b0000);
    end

    // Randomized segments against the model, with occasional resets
    for (int s = 0; s < 150; s++) begin
      rst      = ($urandom_range(0, 40) == 0);
      btn_mode = 1'($urandom_range(0, 1));
      sw_raw   = 4'($urandom_range(0, 15));
      len      = $urandom_range(1, 14);
      step();
      rst = 1'b0;
      repeat (len - 1) step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
